// File: rtl/bit_reverse_accel_pkg.sv
// Shared types and helpers for the bit_reverse_accel stream slices.
// The default beat layout matches the 32-bit payload / 1-bit TLAST channel.
package bit_reverse_accel_pkg;

  localparam int RS_MAX_DEPTH = 16;
  localparam int RS_DATA_W    = 32;
  localparam int RS_USER_W    = 1;

  typedef struct packed {
    logic [RS_USER_W-1:0] user;
    logic [RS_DATA_W-1:0] data;
  } stream_beat_t;

  function automatic int rs_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bit_reverse_accel_regslice_mem.sv
// Storage array for the register slice: one write port, asynchronous read.
// Contents are deliberately left unreset; only the pointers qualify them.
module bit_reverse_accel_regslice_mem
  import bit_reverse_accel_pkg::*;
#(
  parameter  int Width = RS_DATA_W + RS_USER_W,
  parameter  int Depth = 2,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bit_reverse_accel_regslice_deep.sv
// Parametrised elastic vld/ack register slice with flush, occupancy and
// the apdone_blk back-pressure flag used by the HLS done gating.
module bit_reverse_accel_regslice_deep
  import bit_reverse_accel_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int UserWidth = 1,
  parameter int Depth     = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [DataWidth-1:0]       data_in,
  input  logic [UserWidth-1:0]       user_in,
  input  logic                       vld_in,
  output logic                       ack_in,
  output logic [DataWidth-1:0]       data_out,
  output logic [UserWidth-1:0]       user_out,
  output logic                       vld_out,
  input  logic                       ack_out,
  input  logic                       flush,
  output logic [rs_cnt_w(Depth)-1:0] count,
  output logic                       apdone_blk
);

  localparam int PtrW  = $clog2(Depth);
  localparam int CntW  = rs_cnt_w(Depth);
  localparam int BeatW = UserWidth + DataWidth;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  if ((Depth < 2) || (Depth > RS_MAX_DEPTH) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "bit_reverse_accel_regslice_deep: Depth must be a power of two in 2..16");
  end

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  count_next;
  logic             ack_in_q, ack_in_d;
  logic             push;
  logic             pop;
  logic [BeatW-1:0] rd_beat;

  // Flush forces both handshake outputs low so no transfer can complete in that cycle.
  assign ack_in  = ack_in_q & ~flush;
  assign vld_out = (count_q != '0) & ~flush;
  assign push    = vld_in & ack_in;
  assign pop     = vld_out & ack_out;

  always_comb begin
    count_next = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ack_in_d = 1'b1;
    end else begin
      count_d  = count_next;
      wr_ptr_d = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
      // Ready is registered from the next occupancy: a pop while full cannot reopen it this cycle.
      ack_in_d = (count_next != FullCnt);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_in_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_in_q <= ack_in_d;
    end
  end

  bit_reverse_accel_regslice_mem #(
    .Width (BeatW),
    .Depth (Depth)
  ) u_mem (
    .clk     (ap_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({user_in, data_in}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_beat)
  );

  assign {user_out, data_out} = rd_beat;
  assign count      = count_q;
  assign apdone_blk = ((count_q != '0) & ~ack_out) | (count_q == FullCnt);

endmodule

// File: tb/tb_bit_reverse_accel_regslice_deep.sv
// Bench for the deep register slice: a Depth=4 and a Depth=2 instance, each
// checked every cycle against a queue model, plus hand-computed pin checks.
module tb_bit_reverse_accel_regslice_deep;
  import bit_reverse_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld_in   [2];
  logic [31:0] data_in  [2];
  logic        user_in  [2];
  logic        ack_in   [2];
  logic [31:0] data_out [2];
  logic        user_out [2];
  logic        vld_out  [2];
  logic        ack_out  [2];
  logic        flush    [2];
  logic        apdone   [2];
  logic [2:0]  count0;
  logic [1:0]  count1;

  int total = 0;
  int bad   = 0;

  stream_beat_t mq [2][$];
  bit           m_ack [2] = '{1'b0, 1'b0};
  logic [31:0]  col [$];
  bit           col_en = 1'b0;

  always #5 clk = ~clk;

  bit_reverse_accel_regslice_deep #(.DataWidth(32), .UserWidth(1), .Depth(4)) dut4 (
    .ap_clk(clk), .ap_rst(rst), .data_in(data_in[0]), .user_in(user_in[0]),
    .vld_in(vld_in[0]), .ack_in(ack_in[0]), .data_out(data_out[0]),
    .user_out(user_out[0]), .vld_out(vld_out[0]), .ack_out(ack_out[0]),
    .flush(flush[0]), .count(count0), .apdone_blk(apdone[0]));

  bit_reverse_accel_regslice_deep #(.DataWidth(32), .UserWidth(1), .Depth(2)) dut2 (
    .ap_clk(clk), .ap_rst(rst), .data_in(data_in[1]), .user_in(user_in[1]),
    .vld_in(vld_in[1]), .ack_in(ack_in[1]), .data_out(data_out[1]),
    .user_out(user_out[1]), .vld_out(vld_out[1]), .ack_out(ack_out[1]),
    .flush(flush[1]), .count(count1), .apdone_blk(apdone[1]));

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int cnt(input int i);
    return (i == 0) ? int'(count0) : int'(count1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: FIFO queue plus ready that reflects whether last edge left the slice full.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        m_ack[i] = 1'b0;
      end else if (flush[i]) begin
        mq[i].delete();
        m_ack[i] = 1'b1;
      end else begin
        bit pu, po;
        stream_beat_t b;
        pu = vld_in[i] && m_ack[i];
        po = (mq[i].size() != 0) && ack_out[i];
        if (po) void'(mq[i].pop_front());
        if (pu) begin
          b.user = user_in[i];
          b.data = data_in[i];
          mq[i].push_back(b);
        end
        m_ack[i] = (mq[i].size() != dep(i));
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int sz;
      bit ev;
      sz = mq[i].size();
      ev = (sz != 0) && !flush[i];
      chk($sformatf("ack_in[%0d]", i), 64'(ack_in[i]), 64'(m_ack[i] && !flush[i]));
      chk($sformatf("vld_out[%0d]", i), 64'(vld_out[i]), 64'(ev));
      chk($sformatf("count[%0d]", i), 64'(cnt(i)), 64'(sz));
      chk($sformatf("apdone[%0d]", i), 64'(apdone[i]),
          64'(((sz != 0) && !ack_out[i]) || (sz == dep(i))));
      if (ev) begin
        chk($sformatf("data_out[%0d]", i), 64'(data_out[i]), 64'(mq[i][0].data));
        chk($sformatf("user_out[%0d]", i), 64'(user_out[i]), 64'(mq[i][0].user));
      end
    end
  end

  always @(negedge clk) begin
    if (col_en && vld_out[0] && ack_out[0]) col.push_back(data_out[0]);
  end

  // Called at posedge+1; holds the beat until accepted, returns at posedge+1.
  task automatic send(input int i, input logic [31:0] d, input logic u);
    bit done;
    done = 1'b0;
    vld_in[i]  = 1'b1;
    data_in[i] = d;
    user_in[i] = u;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = ack_in[i];
      @(posedge clk);
      #1;
    end
    vld_in[i] = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout[%0d]: got no ack want ack for %0h", i, d);
    end
  endtask

  task automatic wait_empty(input int i);
    bit e;
    e = 1'b0;
    for (int k = 0; k < 200 && !e; k++) begin
      @(posedge clk);
      #1;
      e = (cnt(i) == 0);
    end
    if (!e) begin
      total++;
      bad++;
      $display("FAIL drain_timeout[%0d]: got count %0d want 0", i, cnt(i));
    end
  endtask

  initial begin
    logic [31:0] exp_seq [12];
    for (int i = 0; i < 2; i++) begin
      vld_in[i] = 1'b0; data_in[i] = 32'h0; user_in[i] = 1'b0;
      ack_out[i] = 1'b0; flush[i] = 1'b0;
    end

    // Reset and bring-up
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_in", 64'(ack_in[0]), 64'd0);
    chk("rst_vld_out", 64'(vld_out[0]), 64'd0);
    chk("rst_count", 64'(count0), 64'd0);
    chk("rst_apdone", 64'(apdone[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ack_before_edge", 64'(ack_in[0]), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_after_edge", 64'(ack_in[0]), 64'd1);
    chk("count_after_rel", 64'(count0), 64'd0);
    @(posedge clk); #1;

    // Fill with downstream stalled, then a held fifth beat
    send(0, 32'h11, 1'b0);
    send(0, 32'h22, 1'b1);
    send(0, 32'h33, 1'b0);
    send(0, 32'h44, 1'b1);
    vld_in[0] = 1'b1; data_in[0] = 32'h55; user_in[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_count", 64'(count0), 64'd4);
      chk("full_ack_in", 64'(ack_in[0]), 64'd0);
      chk("full_apdone", 64'(apdone[0]), 64'd1);
      @(posedge clk); #1;
    end

    // Drain while streaming: order 11..44 then 55..5C, pointers wrap
    col_en = 1'b1;
    ack_out[0] = 1'b1;
    for (int k = 0; k < 8; k++) send(0, 32'h55 + 32'(k), 1'(k));
    wait_empty(0);
    col_en = 1'b0;
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
    for (int k = 0; k < 8; k++) exp_seq[4 + k] = 32'h55 + 32'(k);
    chk("drain_len", 64'(col.size()), 64'd12);
    for (int k = 0; k < 12 && k < col.size(); k++)
      chk($sformatf("drain_seq[%0d]", k), 64'(col[k]), 64'(exp_seq[k]));

    // Simultaneous push and pop at count 2
    ack_out[0] = 1'b0;
    send(0, 32'h01, 1'b0);
    send(0, 32'h02, 1'b1);
    vld_in[0] = 1'b1; data_in[0] = 32'hAA; user_in[0] = 1'b0; ack_out[0] = 1'b1;
    @(negedge clk);
    chk("pp_ack_in", 64'(ack_in[0]), 64'd1);
    @(posedge clk); #1;
    vld_in[0] = 1'b0; ack_out[0] = 1'b0;
    @(negedge clk);
    chk("pp_count", 64'(count0), 64'd2);
    chk("pp_head", 64'(data_out[0]), 64'h02);
    @(posedge clk); #1;
    ack_out[0] = 1'b1;
    wait_empty(0);

    // Flush at count 3 with a beat waiting upstream
    ack_out[0] = 1'b0;
    send(0, 32'h31, 1'b0);
    send(0, 32'h32, 1'b0);
    send(0, 32'h33, 1'b0);
    vld_in[0] = 1'b1; data_in[0] = 32'hBB; user_in[0] = 1'b1; flush[0] = 1'b1;
    @(negedge clk);
    chk("fl_ack_in", 64'(ack_in[0]), 64'd0);
    chk("fl_vld_out", 64'(vld_out[0]), 64'd0);
    @(posedge clk); #1 flush[0] = 1'b0;
    @(negedge clk);
    chk("fl_count", 64'(count0), 64'd0);
    chk("fl_ack_after", 64'(ack_in[0]), 64'd1);
    @(posedge clk); #1 vld_in[0] = 1'b0;
    @(negedge clk);
    chk("fl_first_vld", 64'(vld_out[0]), 64'd1);
    chk("fl_first_data", 64'(data_out[0]), 64'hBB);
    chk("fl_first_cnt", 64'(count0), 64'd1);
    @(posedge clk); #1 ack_out[0] = 1'b1;
    wait_empty(0);

    // Random traffic on Depth=4 with back-pressure and occasional flush
    for (int k = 0; k < 2000; k++) begin
      bit acc;
      @(negedge clk);
      acc = vld_in[0] && ack_in[0];
      @(posedge clk); #1;
      if (!vld_in[0] || acc) begin
        vld_in[0]  = 1'($urandom_range(0, 1));
        data_in[0] = $urandom;
        user_in[0] = 1'($urandom_range(0, 1));
      end
      ack_out[0] = 1'($urandom_range(0, 1));
      flush[0]   = ($urandom_range(0, 31) == 0);
    end
    vld_in[0] = 1'b0; flush[0] = 1'b0; ack_out[0] = 1'b1;
    wait_empty(0);

    // Depth=2 streaming: one beat per cycle, no bubbles on either side
    ack_out[1] = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      vld_in[1]  = 1'b1;
      data_in[1] = $urandom;
      user_in[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stream_ack_in", 64'(ack_in[1]), 64'd1);
      if (n > 0) chk("stream_vld_out", 64'(vld_out[1]), 64'd1);
      @(posedge clk); #1;
    end
    vld_in[1] = 1'b0;
    wait_empty(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_reverse_accel_regslice_deep.md
# bit_reverse_accel_regslice_deep

Parametrised elastic register slice for the bit_reverse_accel AXI-Stream-style vld/ack channels, replacing the fixed two-entry slice. Storage depth, data width and a sideband field (TLAST/TUSER) are configurable. It adds a synchronous flush and an occupancy output. It sits on every accelerator stream boundary (input and output) between the HLS core and the interconnect, and keeps the `apdone_blk` back-pressure indication the HLS control logic expects.

## Interface
- `DataWidth`, 32, payload width in bits (≥1).
- `UserWidth`, 1, sideband width carried in lock-step with the payload (≥1).
- `Depth`, 2, number of storage entries; power of two, 2..16.
- `ap_clk` in 1: the single clock; all logic is rising-edge.
- `ap_rst` in 1: reset, asynchronous and active-high.
- `data_in` in DataWidth: upstream payload.
- `user_in` in UserWidth: upstream sideband.
- `vld_in` in 1: upstream valid.
- `ack_in` out 1: ready to upstream.
- `data_out` out DataWidth: head-entry payload.
- `user_out` out UserWidth: head-entry sideband.
- `vld_out` out 1: head entry valid.
- `ack_out` in 1: downstream ready.
- `flush` in 1: synchronous discard of all entries.
- `count` out $clog2(Depth)+1: registered occupancy, 0..Depth.
- `apdone_blk` out 1: output blocked, for HLS done gating.

## Operation
- Storage is a circular buffer of Depth entries {user, data}, with `wr_ptr`/`rd_ptr` of $clog2(Depth) bits. Pointers wrap from Depth-1 to 0 naturally.
- Push happens when `vld_in & ack_in`: the entry is written at `wr_ptr`, then `wr_ptr`+1.
- Pop happens when `vld_out & ack_out`: `rd_ptr`+1.
- `count_next = count + push - pop`. A simultaneous push and pop leaves `count` unchanged.
- `ack_in` is registered: `ack_in_q <= (count_next != Depth)`, then gated by `~flush`. With `count==Depth`, `ack_in`=0, even if a pop occurs in that cycle. There is no combinational ready path from `ack_out` to `ack_in`.
- `vld_out = (count != 0) & ~flush`.
- `data_out`/`user_out` = storage[`rd_ptr`]. The value is don't-care while `vld_out`=0.
- There is no fall-through. An empty slice never forwards `data_in` in the same cycle.
- Flush has priority over push/pop. On a flush edge, `count`, `wr_ptr` and `rd_ptr` go to 0 and `ack_in_q` goes to 1. No handshake completes in a flush cycle because both ready/valid outputs are forced low.
- `apdone_blk = ((count != 0) & ~ack_out) | (count == Depth)`.
- Payload/user storage is not reset. Pointers, `count` and `ack_in_q` are reset.

## Timing
- Reset values (asynchronous, while `ap_rst`=1):
  - `ack_in`=0, `vld_out`=0, `count`=0, `apdone_blk`=0 (for `ack_out` either value and `count`=0).
- Reset release: `ack_in` rises at the first `ap_clk` edge after `ap_rst` deasserts.
- Latency: a word pushed at edge k is presented with `vld_out`=1 after edge k, which is 1 cycle.
- Throughput: 1 word/cycle sustained in steady state when `ack_out`=1 continuously, for any Depth ≥2.
- Full boundary: the push that makes `count==Depth` drops `ack_in` after the same edge.
- Empty boundary: the pop of the last entry drops `vld_out` after that edge unless a push happens in the same cycle.
- Reset asserted mid-transfer: all entries are lost, with no partial handshake. Upstream must resend.
- Handshake rules: `vld_in`/`data_in` must be held until accepted. Outputs honour the same rule: `data_out` is stable while `vld_out & ~ack_out`.

## Structure
- Shared package `bit_reverse_accel_pkg` holds:
  - `RS_MAX_DEPTH=16`;
  - a function `rs_cnt_w(depth)` returning $clog2(depth)+1;
  - the `stream_beat_t` struct {user, data} used by all stream slices.
- One sub-module, `bit_reverse_accel_regslice_mem`: a Depth×(UserWidth+DataWidth) register array with write enable/address and an asynchronous read address.
- Pointer, count and ready logic stays in the top module.
- Elaboration-time assertion: Depth is a power of two in 2..RS_MAX_DEPTH.

## Test plan
- Reset/bring-up, Depth=4: `ap_rst` pulse → `ack_in`=0 and `vld_out`=0 during reset. `ack_in`=1 one edge after release and `count`=0.
- Fill/back-pressure, Depth=4, `ack_out`=0: push 0x11,0x22,0x33,0x44 → `count`=4 and `ack_in`=0. A fifth beat 0x55 is held and not accepted. `apdone_blk`=1.
- Drain order and wrap: from the full state, set `ack_out`=1 and push 0x55..0x5C continuously. The output sequence is 0x11,0x22,0x33,0x44,0x55..0x5C with no gaps; pointers wrap twice.
- Streaming, Depth=2: push 1000 random beats with random `user_in` while `ack_out`=1. Output must be identical in order. After the first beat, `vld_out` stays 1 every cycle.
- Simultaneous push/pop at `count`=2, Depth=4: push 0xAA and pop in the same cycle → `count` stays 2 and the next head beat is correct.
- Flush at `count`=3 with `vld_in`=1 (0xBB): in the flush cycle `ack_in`=0 and `vld_out`=0. Next cycle `count`=0 and `ack_in`=1. 0xBB is accepted afterwards and becomes the first output.
